// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues req/ack memory reads and queues
// fetched words (tagged with their PC) in a small FIFO toward the IR.
// Optional build macro FETCH_PERF_EN adds saturating fetch/squash counters.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc_out
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       fetch_cnt,
    output logic [15:0]       squash_cnt
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, REQ, STALL} state_t;

    state_t             state, next_state;
    logic               squash, squash_next;
    logic [ADDR_W-1:0]  pc_next;
    logic [ADDR_W-1:0]  addr_next;
    logic [CNT_W-1:0]   count, count_next;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [DATA_W-1:0]  fifo_data [DEPTH];
    logic [ADDR_W-1:0]  fifo_pc   [DEPTH];
    logic               ack_c, push_c, pop_c, drop_c;

    // FIFO head is presented straight from storage
    assign instr_valid = (count != '0);
    assign instr_data  = fifo_data[rd_ptr];
    assign instr_pc    = fifo_pc[rd_ptr];

    // Handshake qualification: acks without a live request are ignored
    assign ack_c  = mem_ack & mem_req;
    assign push_c = ack_c & ~squash & ~redirect_valid;
    assign drop_c = ack_c & (squash | redirect_valid);
    assign pop_c  = instr_valid & instr_ready & ~redirect_valid;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state, occupancy, PC and request address
    always_comb begin
        next_state  = state;
        squash_next = squash;
        count_next  = count + CNT_W'(push_c) - CNT_W'(pop_c);
        pc_next     = push_c ? pc_out + ADDR_W'(1) : pc_out;
        addr_next   = mem_addr;

        if (redirect_valid) begin
            count_next = '0;
            pc_next    = redirect_pc;
        end

        // Outstanding request survives a redirect; its data is dropped on ack
        if (redirect_valid && mem_req && !mem_ack) squash_next = 1'b1;
        else if (ack_c)                            squash_next = 1'b0;

        case (state)
            IDLE:    if (count_next < CNT_W'(DEPTH)) next_state = REQ;
            REQ:     if (ack_c && count_next >= CNT_W'(DEPTH)) next_state = STALL;
            STALL:   if (count_next < CNT_W'(DEPTH)) next_state = REQ;
            default: next_state = IDLE;
        endcase

        // New address only when a fresh request starts
        if (next_state == REQ && (state != REQ || ack_c)) addr_next = pc_next;
    end

    // Request, PC and FIFO datapath
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
            pc_out   <= RESET_PC;
            squash   <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else begin
            mem_req  <= (next_state == REQ);
            mem_addr <= addr_next;
            pc_out   <= pc_next;
            squash   <= squash_next;
            count    <= count_next;
            if (redirect_valid) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_c) begin
                    fifo_data[wr_ptr] <= mem_rdata;
                    fifo_pc[wr_ptr]   <= pc_out;
                    wr_ptr            <= wr_ptr + PTR_W'(1);
                end
                if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [16:0] fetch_sum_c;
    logic [16:0] squash_sum_c;

    assign fetch_sum_c  = {1'b0, fetch_cnt} + 17'(push_c);
    assign squash_sum_c = {1'b0, squash_cnt} + 17'(drop_c)
                        + (redirect_valid ? 17'(count) : 17'd0);

    // Saturating performance counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt  <= '0;
            squash_cnt <= '0;
        end else begin
            fetch_cnt  <= fetch_sum_c[16]  ? 16'hFFFF : fetch_sum_c[15:0];
            squash_cnt <= squash_sum_c[16] ? 16'hFFFF : squash_sum_c[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic [15:0] pc_out;
`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt;
    logic [15:0] squash_cnt;
`endif

    int total = 0;
    int bad   = 0;

    instr_fetch_unit dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .pc_out         (pc_out)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt      (fetch_cnt),
        .squash_cnt     (squash_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        mem_ack        = 1'b0;
        mem_rdata      = 16'h0;
        instr_ready    = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        redirect_valid = 1'b0;
        mem_ack = 1'b0;
        instr_ready = 1'b0;
        repeat (3) tick();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_instr_valid got %b want 0", instr_valid); end
        total++; if (pc_out !== 16'h0000) begin bad++; $display("FAIL reset_pc_out got %h want 0000", pc_out); end
        total++; if (mem_addr !== 16'h0000) begin bad++; $display("FAIL reset_mem_addr got %h want 0000", mem_addr); end
        total++; if (instr_data !== 16'h0000 || instr_pc !== 16'h0000) begin
            bad++; $display("FAIL reset_head got data=%h pc=%h want 0000/0000", instr_data, instr_pc);
        end
    endtask

    // Ready held high, memory acks one cycle after each request
    task automatic test_streaming();
        int got;
        int wt;
        do_reset();
        instr_ready = 1'b1;
        got = 0;
        wt  = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            if (instr_valid) begin
                total++; if (instr_pc !== 16'(got)) begin bad++; $display("FAIL stream_pc[%0d] got %h want %h", got, instr_pc, 16'(got)); end
                total++; if (instr_data !== 16'hA000 + 16'(got)) begin bad++; $display("FAIL stream_data[%0d] got %h want %h", got, instr_data, 16'hA000 + 16'(got)); end
                got++;
            end
            if (mem_req && wt >= 1) begin
                mem_ack = 1'b1; mem_rdata = 16'hA000 + mem_addr; wt = 0;
            end else begin
                mem_ack = 1'b0; if (mem_req) wt++;
            end
            tick();
        end
        mem_ack = 1'b0;
        instr_ready = 1'b0;
        total++; if (got != 4) begin bad++; $display("FAIL stream_timeout got %0d words want 4", got); end
    endtask

    task automatic test_backpressure();
        int wt;
        do_reset();
        wt = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (mem_req && wt >= 1) begin
                mem_ack = 1'b1; mem_rdata = 16'hA000 + mem_addr; wt = 0;
            end else begin
                mem_ack = 1'b0; if (mem_req) wt++;
            end
            tick();
        end
        mem_ack = 1'b0;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL bp_stall_req got %b want 0", mem_req); end
        total++; if (pc_out !== 16'h0002) begin bad++; $display("FAIL bp_pc_out got %h want 0002", pc_out); end
        total++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || instr_data !== 16'hA000) begin
            bad++; $display("FAIL bp_head got v=%b pc=%h data=%h want 1/0000/A000", instr_valid, instr_pc, instr_data);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0002) begin
            bad++; $display("FAIL bp_resume got req=%b addr=%h want 1/0002", mem_req, mem_addr);
        end
        total++; if (instr_pc !== 16'h0001 || instr_data !== 16'hA001) begin
            bad++; $display("FAIL bp_second_head got pc=%h data=%h want 0001/A001", instr_pc, instr_data);
        end
        repeat (3) tick();
        total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0002) begin
            bad++; $display("FAIL bp_hold got req=%b addr=%h want 1/0002", mem_req, mem_addr);
        end
    endtask

    // Stream until a fresh request to target_addr has just been issued
    task automatic stream_to(input logic [15:0] target_addr, output logic found);
        int wt;
        wt = 0;
        found = 1'b0;
        for (int cyc = 0; cyc < 40 && !found; cyc++) begin
            if (mem_req && mem_addr == target_addr && wt == 0) begin
                found = 1'b1;
            end else begin
                if (mem_req && wt >= 1) begin
                    mem_ack = 1'b1; mem_rdata = 16'hA000 + mem_addr; wt = 0;
                end else begin
                    mem_ack = 1'b0; if (mem_req) wt++;
                end
                tick();
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_redirect_mid_req();
        logic found;
        do_reset();
        instr_ready = 1'b1;
        stream_to(16'h0005, found);
        total++; if (!found) begin bad++; $display("FAIL rmr_timeout got no request to 0005"); end
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        tick();
        redirect_valid = 1'b0;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rmr_flush got %b want 0", instr_valid); end
        total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0005) begin
            bad++; $display("FAIL rmr_old_held got req=%b addr=%h want 1/0005", mem_req, mem_addr);
        end
        tick();
        mem_ack = 1'b1; mem_rdata = 16'hA005;
        tick();
        mem_ack = 1'b0;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rmr_dropped got valid=%b pc=%h want 0", instr_valid, instr_pc); end
        total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0040) begin
            bad++; $display("FAIL rmr_new_addr got req=%b addr=%h want 1/0040", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 16'hB040;
        tick();
        mem_ack = 1'b0;
        total++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0040 || instr_data !== 16'hB040) begin
            bad++; $display("FAIL rmr_first_word got v=%b pc=%h data=%h want 1/0040/B040", instr_valid, instr_pc, instr_data);
        end
    endtask

    task automatic test_redirect_ack_pop();
        logic found;
        do_reset();
        instr_ready = 1'b1;
        stream_to(16'h0002, found);
        total++; if (!found || instr_valid !== 1'b1) begin
            bad++; $display("FAIL rap_setup got found=%b valid=%b want 1/1", found, instr_valid);
        end
        mem_ack = 1'b1; mem_rdata = 16'hA002;
        redirect_valid = 1'b1; redirect_pc = 16'h0123;
        tick();
        mem_ack = 1'b0; redirect_valid = 1'b0;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rap_no_stale got valid=%b pc=%h want 0", instr_valid, instr_pc); end
        total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0123) begin
            bad++; $display("FAIL rap_new_addr got req=%b addr=%h want 1/0123", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 16'hC123;
        tick();
        mem_ack = 1'b0;
        total++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0123 || instr_data !== 16'hC123) begin
            bad++; $display("FAIL rap_word got v=%b pc=%h data=%h want 1/0123/C123", instr_valid, instr_pc, instr_data);
        end
        total++; if (pc_out !== 16'h0124) begin bad++; $display("FAIL rap_pc_out got %h want 0124", pc_out); end
    endtask

    task automatic test_wrap();
        do_reset();
        tick();
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
        tick();
        mem_ack = 1'b0; redirect_valid = 1'b0;
        total++; if (mem_addr !== 16'hFFFF || instr_valid !== 1'b0) begin
            bad++; $display("FAIL wrap_redirect got addr=%h valid=%b want FFFF/0", mem_addr, instr_valid);
        end
        mem_ack = 1'b1; mem_rdata = 16'hD0FF;
        tick();
        mem_ack = 1'b0;
        total++; if (instr_pc !== 16'hFFFF || instr_data !== 16'hD0FF) begin
            bad++; $display("FAIL wrap_first got pc=%h data=%h want FFFF/D0FF", instr_pc, instr_data);
        end
        total++; if (pc_out !== 16'h0000 || mem_addr !== 16'h0000 || mem_req !== 1'b1) begin
            bad++; $display("FAIL wrap_pc got pc=%h addr=%h req=%b want 0000/0000/1", pc_out, mem_addr, mem_req);
        end
        mem_ack = 1'b1; mem_rdata = 16'hD000;
        tick();
        mem_ack = 1'b0;
        total++; if (pc_out !== 16'h0001 || mem_req !== 1'b0) begin
            bad++; $display("FAIL wrap_full got pc=%h req=%b want 0001/0", pc_out, mem_req);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        total++; if (instr_pc !== 16'h0000 || instr_data !== 16'hD000) begin
            bad++; $display("FAIL wrap_second got pc=%h data=%h want 0000/D000", instr_pc, instr_data);
        end
`ifdef FETCH_PERF_EN
        total++; if (fetch_cnt !== 16'd2) begin bad++; $display("FAIL wrap_fetch_cnt got %0d want 2", fetch_cnt); end
        total++; if (squash_cnt !== 16'd1) begin bad++; $display("FAIL wrap_squash_cnt got %0d want 1", squash_cnt); end
`endif
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        tick();
        reset_n = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0 || pc_out !== 16'h0000) begin
            bad++; $display("FAIL rst_async got req=%b pc=%h want 0/0000", mem_req, pc_out);
        end
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        tick();
        reset_n = 1'b1;
        tick();
        mem_ack = 1'b0;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_late_ack got valid=%b want 0", instr_valid); end
        total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
            bad++; $display("FAIL rst_restart got req=%b addr=%h want 1/0000", mem_req, mem_addr);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0;
        mem_ack = 1'b0;
        mem_rdata = 16'h0;
        instr_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect_mid_req();
        test_redirect_ack_pop();
        test_wrap();
        test_reset_mid_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
